share_arbiter: RTL and testbench
================================

SHARE_ARBITER -- requirements
Module: share_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 1023: maximum consecutive cycles one requester may hold the shared memory port.
REQ-002 The module SHALL have parameter GAP_CYC, default 2: idle cycles with both busy outputs low between any two grants; legal range 1..15.
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_1  in  1  requester 1 wants the shared word-write/old-word-read port; held high until done.
REQ-006 req_2  in  1  same for requester 2.
REQ-007 done_1  in  1  one-cycle pulse: requester 1 finished its access burst.
REQ-008 done_2  in  1  same for requester 2.
REQ-009 busy_1  out  1  registered grant to requester 1; drives the shared-port mux select.
REQ-010 busy_2  out  1  registered grant to requester 2.
REQ-011 last_owner  out  1  0 = requester 1, 1 = requester 2 was granted most recently.
REQ-012 timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.
REQ-013 timeout_id  out  1  identity of the requester revoked by the latest timeout; holds until the next timeout.

Function
REQ-014 busy_1 and busy_2 SHALL never be high in the same cycle.
REQ-015 FSM states SHALL be IDLE, OWN1, OWN2, GAP.
REQ-016 In IDLE, if req_1 is high and req_2 is low, the next state SHALL be OWN1; if req_2 is high and req_1 is low, OWN2; if neither is high, IDLE.
REQ-017 In IDLE with both requests high, the block SHALL grant the requester that is not last_owner (round robin).
REQ-018 busy_x SHALL rise on the clock edge that enters OWNx: one cycle after the request is sampled in IDLE.
REQ-019 Entering OWNx SHALL update last_owner and clear the hold timer.
REQ-020 In OWNx, done_x high or req_x low SHALL move the FSM to GAP, and busy_x SHALL fall on that edge.
REQ-021 In OWNx, the hold timer SHALL increment each cycle.
REQ-022 When the hold timer equals TIMEOUT_CYC-1 and neither done_x nor a req_x drop is present, the FSM SHALL move to GAP, pulse timeout_err for one cycle and load timeout_id with x.
REQ-023 When done_x and the timeout condition occur in the same cycle, done SHALL win and timeout_err SHALL stay low.
REQ-024 done pulses and requests from the non-owner SHALL be ignored during OWNx; the non-owner's request SHALL stay pending.
REQ-025 GAP SHALL last exactly GAP_CYC cycles and then enter IDLE; arbitration happens in IDLE, so the grant-to-grant spacing is GAP_CYC+1 cycles.
REQ-026 A requester revoked by timeout whose request is still high SHALL be re-granted after GAP only if the other requester is not requesting.
REQ-027 The hold timer width SHALL be $clog2(TIMEOUT_CYC+1) and SHALL saturate; it SHALL never wrap.

Reset
REQ-028 While reset is low, the block SHALL asynchronously force state IDLE, busy_1=0, busy_2=0, last_owner=1 (so requester 1 wins the first tie), timeout_err=0, timeout_id=0, all counters 0.
REQ-029 Reset asserted in OWNx SHALL drop busy_x immediately, without waiting for a clock edge.
REQ-030 After reset release, the first grant SHALL be able to occur at the second rising edge at the earliest.

Structure
REQ-031 Package share_arb_pkg SHALL hold the FSM state enum and the default TIMEOUT_CYC and GAP_CYC constants.
REQ-032 One sub-module, hold_timer, SHALL contain the clearable, saturating counter with a terminal-count output; the same module SHALL be instantiated for both the hold timer and the GAP counter.

Verification (TIMEOUT_CYC=8, GAP_CYC=2)
REQ-033 Stimulus: req_1 rises at cycle 0, done_1 pulses at cycle 5. Required: busy_1 high in cycles 1-5, low in cycle 6; no grant in cycles 6-7; last_owner=0.
REQ-034 Stimulus: req_1 and req_2 rise together right after reset. Required: busy_1 granted first; after done_1, busy_2 rises exactly GAP_CYC+1 cycles after busy_1 falls.
REQ-035 Stimulus: req_2 held high with no done. Required: busy_2 high for 8 cycles; timeout_err pulses once with timeout_id=1; after the gap, busy_2 is re-granted.
REQ-036 Stimulus: both requesters held high, with requester 1 timing out. Required: the next grant goes to requester 2, and busy is never high for both in the same cycle.
REQ-037 Stimulus: done_1 coincides with the 8th hold cycle. Required: timeout_err=0 and a normal release.
REQ-038 Stimulus: reset asserted mid-OWN2 between clock edges. Required: busy_2=0 immediately, and all outputs at their reset values.

Source files
------------

// File: rtl/share_arb_pkg.sv
// Shared types and default sizing for the two-requester memory-port arbiter.
package share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  localparam int DEF_TIMEOUT_CYC = 1023;
  localparam int DEF_GAP_CYC     = 2;

endpackage

// File: rtl/share_arbiter_hold_timer.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
// tc flags the cycle in which the count equals TC_VAL.
module hold_timer #(
  parameter int WIDTH  = 4,
  parameter int TC_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == WIDTH'(TC_VAL));

endmodule

// File: rtl/share_arbiter.sv
// Round-robin owner of a shared memory port between two requesters, with a
// hold timeout and a fixed idle gap between consecutive grants.
module share_arbiter #(
  parameter int TIMEOUT_CYC = share_arb_pkg::DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = share_arb_pkg::DEF_GAP_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic req_1,
  input  logic req_2,
  input  logic done_1,
  input  logic done_2,
  output logic busy_1,
  output logic busy_2,
  output logic last_owner,
  output logic timeout_err,
  output logic timeout_id
);

  import share_arb_pkg::*;

  localparam int HOLD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W  = 4;

  arb_state_e state_q, state_d;
  logic busy_1_q, busy_1_d;
  logic busy_2_q, busy_2_d;
  logic last_owner_q, last_owner_d;
  logic timeout_err_q, timeout_err_d;
  logic timeout_id_q, timeout_id_d;
  logic started_q;
  logic in_own, in_gap;
  logic hold_tc, gap_tc;
  logic timeout;

  assign in_own = (state_q == OWN1) || (state_q == OWN2);
  assign in_gap = (state_q == GAP);

  // Both counters sit at zero outside their state, so entry always starts from 0.
  hold_timer #(.WIDTH(HOLD_W), .TC_VAL(TIMEOUT_CYC - 1)) u_hold_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr   (!in_own),
    .en    (in_own),
    .tc    (hold_tc)
  );

  hold_timer #(.WIDTH(GAP_W), .TC_VAL(GAP_CYC - 1)) u_gap_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr   (!in_gap),
    .en    (in_gap),
    .tc    (gap_tc)
  );

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        // started_q holds off arbitration for the first edge after reset release.
        if (started_q) begin
          if (req_1 && req_2) begin
            state_d = last_owner_q ? OWN1 : OWN2;
          end else if (req_1) begin
            state_d = OWN1;
          end else if (req_2) begin
            state_d = OWN2;
          end
        end
      end
      OWN1: begin
        if (done_1 || !req_1) begin
          state_d = GAP;
        end else if (hold_tc) begin
          state_d = GAP;
          timeout = 1'b1;
        end
      end
      OWN2: begin
        if (done_2 || !req_2) begin
          state_d = GAP;
        end else if (hold_tc) begin
          state_d = GAP;
          timeout = 1'b1;
        end
      end
      GAP: begin
        if (gap_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_1_d      = (state_d == OWN1);
    busy_2_d      = (state_d == OWN2);
    last_owner_d  = last_owner_q;
    if (state_q == IDLE && state_d == OWN1) begin
      last_owner_d = 1'b0;
    end else if (state_q == IDLE && state_d == OWN2) begin
      last_owner_d = 1'b1;
    end
    timeout_err_d = timeout;
    timeout_id_d  = timeout ? (state_q == OWN2) : timeout_id_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      busy_1_q      <= 1'b0;
      busy_2_q      <= 1'b0;
      last_owner_q  <= 1'b1;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_1_q      <= busy_1_d;
      busy_2_q      <= busy_2_d;
      last_owner_q  <= last_owner_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
      started_q     <= 1'b1;
    end
  end

  assign busy_1      = busy_1_q;
  assign busy_2      = busy_2_q;
  assign last_owner  = last_owner_q;
  assign timeout_err = timeout_err_q;
  assign timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_share_arbiter.sv
// Directed bench for share_arbiter with TIMEOUT_CYC=8, GAP_CYC=2.
module tb_share_arbiter;

  logic clk;
  logic reset;
  logic req_1, req_2, done_1, done_2;
  logic busy_1, busy_2, last_owner, timeout_err, timeout_id;

  int total = 0;
  int bad   = 0;

  share_arbiter #(.TIMEOUT_CYC(8), .GAP_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_1       (req_1),
    .req_2       (req_2),
    .done_1      (done_1),
    .done_2      (done_2),
    .busy_1      (busy_1),
    .busy_2      (busy_2),
    .last_owner  (last_owner),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy1"}, busy_1, 0);
    chk({tag, "_busy2"}, busy_2, 0);
    chk({tag, "_last"},  last_owner, 1);
    chk({tag, "_terr"},  timeout_err, 0);
    chk({tag, "_tid"},   timeout_id, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req_1 = 1'b0; req_2 = 1'b0; done_1 = 1'b0; done_2 = 1'b0;
    #12;
    chk_reset_vals("rst");
    #1 reset = 1'b1;
    tick();

    // Single requester with a done pulse at cycle 5.
    req_1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("t1_busy1_on", busy_1, 1);
      if (c == 5) begin
        done_1 = 1'b1;
        req_1  = 1'b0;
      end
    end
    tick();
    done_1 = 1'b0;
    chk("t1_busy1_off", busy_1, 0);
    chk("t1_last", last_owner, 0);
    tick();
    chk("t1_gap_nogrant", busy_1 | busy_2, 0);

    // Tie right after reset; requests already high at release.
    reset = 1'b0; req_1 = 1'b1; req_2 = 1'b1;
    #3 reset = 1'b1;
    tick();
    chk("t2_first_edge_nogrant", busy_1 | busy_2, 0);
    tick();
    chk("t2_busy1_first", busy_1, 1);
    chk("t2_busy2_low", busy_2, 0);
    tick();
    tick();
    done_1 = 1'b1; req_1 = 1'b0;
    tick();
    done_1 = 1'b0;
    chk("t2_busy1_fall", busy_1, 0);
    for (int c = 4; c <= 6; c++) begin
      chk("t2_busy2_wait", busy_2, 0);
      tick();
    end
    chk("t2_busy2_rise", busy_2, 1);
    done_2 = 1'b1; req_2 = 1'b0;
    tick();
    done_2 = 1'b0;
    chk("t2_busy2_fall", busy_2, 0);
    idle(3);

    // Requester 2 never finishes: timeout then re-grant.
    req_2 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t3_busy2_hold", busy_2, 1);
      chk("t3_terr_low", timeout_err, 0);
    end
    tick();
    chk("t3_busy2_revoked", busy_2, 0);
    chk("t3_terr_pulse", timeout_err, 1);
    chk("t3_tid", timeout_id, 1);
    tick();
    chk("t3_terr_once", timeout_err, 0);
    tick();
    chk("t3_idle_nogrant", busy_2, 0);
    tick();
    chk("t3_regrant", busy_2, 1);
    chk("t3_last", last_owner, 1);
    req_2 = 1'b0;
    tick();
    chk("t3_release", busy_2, 0);
    idle(3);

    // done_1 on the 8th hold cycle beats the timeout.
    req_1 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t5_busy1_hold", busy_1, 1);
      if (c == 8) done_1 = 1'b1;
    end
    tick();
    chk("t5_busy1_released", busy_1, 0);
    chk("t5_terr_low", timeout_err, 0);
    chk("t5_tid_held", timeout_id, 1);
    done_1 = 1'b0; req_1 = 1'b0;
    tick();
    chk("t5_terr_still_low", timeout_err, 0);
    idle(3);

    // Asynchronous reset in the middle of an OWN2 cycle.
    req_2 = 1'b1;
    tick();
    tick();
    chk("t6_busy2_owned", busy_2, 1);
    #3 reset = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    req_2 = 1'b0;
    tick();
    chk("t6_hold_in_reset", busy_2, 0);
    #3 reset = 1'b1;
    tick();

    // Both requesting continuously; requester 1 times out first.
    req_1 = 1'b1; req_2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("t4_exclusive", busy_1 & busy_2, 0);
      if (c == 1) chk("t4_busy1_first", busy_1, 1);
      if (c == 8) chk("t4_busy1_last_cycle", busy_1, 1);
      if (c == 9) begin
        chk("t4_busy1_revoked", busy_1, 0);
        chk("t4_terr", timeout_err, 1);
        chk("t4_tid", timeout_id, 0);
      end
      if (c == 12) begin
        chk("t4_busy2_next", busy_2, 1);
        chk("t4_busy1_not_regranted", busy_1, 0);
      end
    end
    req_1 = 1'b0; req_2 = 1'b0;
    tick();
    chk("t4_release", busy_1 | busy_2, 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
